// File: rtl/scr1_dmem_router_mp.sv
// Data-memory router: decodes core DMEM requests onto PORT_NUM targets by mask/pattern and keeps
// up to OUTSTD_DEPTH in-order outstanding transactions; unmapped requests get an internal RDY_ER.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_dmem_router_mp #(
    parameter int unsigned                               PORT_NUM     = 4,
    parameter logic [PORT_NUM*`SCR1_DMEM_AWIDTH-1:0]     ADDR_MASK    = '0,
    parameter logic [PORT_NUM*`SCR1_DMEM_AWIDTH-1:0]     ADDR_PATTERN = '0,
    parameter int unsigned                               DEFAULT_PORT = 0,
    parameter int unsigned                               OUTSTD_DEPTH = 2
) (
    input  logic                                rst_n,
    input  logic                                clk,
    input  logic                                dmem_req,
    output logic                                dmem_req_ack,
    input  logic                                dmem_cmd,
    input  logic [1:0]                          dmem_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]        dmem_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]        dmem_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0]        dmem_rdata,
    output logic [1:0]                          dmem_resp,
    output logic [PORT_NUM-1:0]                 port_req,
    input  logic [PORT_NUM-1:0]                 port_req_ack,
    output logic                                port_cmd,
    output logic [1:0]                          port_width,
    output logic [`SCR1_DMEM_AWIDTH-1:0]        port_addr,
    output logic [`SCR1_DMEM_DWIDTH-1:0]        port_wdata,
    input  logic [PORT_NUM*`SCR1_DMEM_DWIDTH-1:0] port_rdata,
    input  logic [PORT_NUM*2-1:0]               port_resp
);

    localparam int unsigned AW = `SCR1_DMEM_AWIDTH;
    localparam int unsigned DW = `SCR1_DMEM_DWIDTH;
    localparam int unsigned IW = $clog2(PORT_NUM + 1);
    localparam int unsigned PW = (OUTSTD_DEPTH > 1) ? $clog2(OUTSTD_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OUTSTD_DEPTH + 1);

    typedef enum logic [1:0] {
        RESP_NOTRDY = 2'd0,
        RESP_RDY_OK = 2'd1,
        RESP_RDY_ER = 2'd2
    } resp_e;

    logic [IW-1:0] r_fifo [OUTSTD_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [IW-1:0] w_sel;
    logic          w_found;
    logic [IW-1:0] w_head;
    logic [IW-1:0] w_tail;
    logic [PW-1:0] w_tail_ptr;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    resp_e         w_head_resp;
    logic [DW-1:0] w_head_rdata;
    logic          w_pop;
    logic          w_push;
    logic          w_issue_ok;
    logic          w_tgt_ack;

    // Lowest-index matching port wins; no match falls back to DEFAULT_PORT
    always_comb begin
        w_sel   = IW'(DEFAULT_PORT);
        w_found = 1'b0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            if (!w_found && ((dmem_addr & ADDR_MASK[i*AW +: AW]) == ADDR_PATTERN[i*AW +: AW])) begin
                w_sel   = IW'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_head     = r_fifo[r_rptr];
    assign w_tail_ptr = (r_wptr == '0) ? PW'(OUTSTD_DEPTH - 1) : r_wptr - PW'(1);
    assign w_tail     = r_fifo[w_tail_ptr];
    assign w_wptr_nxt = (r_wptr == PW'(OUTSTD_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
    assign w_rptr_nxt = (r_rptr == PW'(OUTSTD_DEPTH - 1)) ? '0 : r_rptr + PW'(1);

    // Head index == PORT_NUM is the internal error slot, which answers RDY_ER as soon as it is at head
    always_comb begin
        w_head_resp  = RESP_NOTRDY;
        w_head_rdata = '0;
        if (r_count != '0) begin
            w_head_resp = RESP_RDY_ER;
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                if (w_head == IW'(i)) begin
                    w_head_resp  = resp_e'(port_resp[i*2 +: 2]);
                    w_head_rdata = port_rdata[i*DW +: DW];
                end
            end
        end
    end

    assign w_pop = (w_head_resp != RESP_NOTRDY);

    // New requests only follow entries to the same target, so responses stay in order
    assign w_issue_ok = dmem_req
                      & ((r_count < CW'(OUTSTD_DEPTH)) | w_pop)
                      & ((r_count == '0) | (w_sel == w_tail) | ((r_count == CW'(1)) & w_pop));

    always_comb begin
        w_tgt_ack = (w_sel == IW'(PORT_NUM));
        port_req  = '0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            if (w_sel == IW'(i)) begin
                w_tgt_ack   = port_req_ack[i];
                port_req[i] = w_issue_ok;
            end
        end
    end

    assign w_push       = w_issue_ok & w_tgt_ack;
    assign dmem_req_ack = w_push;
    assign dmem_resp    = w_head_resp;
    assign dmem_rdata   = w_head_rdata;

    assign port_cmd   = dmem_cmd;
    assign port_width = dmem_width;
    assign port_addr  = dmem_addr;
    assign port_wdata = dmem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < OUTSTD_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

`ifndef SYNTHESIS
    a_onehot_req: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(port_req));
    a_count_max:  assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(OUTSTD_DEPTH));
    a_no_x_req:   assert property (@(posedge clk) disable iff (!rst_n)
                                   dmem_req |-> !$isunknown({w_sel, dmem_cmd, dmem_width}));
`endif

endmodule

// File: tb/tb_scr1_dmem_router_mp.sv
// Self-checking bench for scr1_dmem_router_mp: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-queue model of the router.
module tb_scr1_dmem_router_mp;

    localparam int PN    = 4;
    localparam int DEPTH = 2;
    localparam logic [1:0] R_NOT = 2'd0;
    localparam logic [1:0] R_OK  = 2'd1;
    localparam logic [1:0] R_ER  = 2'd2;
    localparam logic [31:0] MASKS [PN] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hF0000000};
    localparam logic [31:0] PATS  [PN] = '{32'h00000000, 32'h00010000, 32'h00020000, 32'h00000000};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dmem_req, dmem_req_ack, dmem_cmd;
    logic [1:0]        dmem_width, dmem_resp;
    logic [31:0]       dmem_addr, dmem_wdata, dmem_rdata;
    logic [PN-1:0]     port_req, port_req_ack;
    logic              port_cmd;
    logic [1:0]        port_width;
    logic [31:0]       port_addr, port_wdata;
    logic [PN*32-1:0]  port_rdata;
    logic [PN*2-1:0]   port_resp;
    logic [31:0]       drv_rdata [PN];
    logic [1:0]        drv_resp  [PN];

    for (genvar g = 0; g < PN; g++) begin : g_pack
        assign port_rdata[g*32 +: 32] = drv_rdata[g];
        assign port_resp[g*2 +: 2]    = drv_resp[g];
    end

    always #5 clk = ~clk;

    scr1_dmem_router_mp #(
        .PORT_NUM     (PN),
        .ADDR_MASK    ({32'hF0000000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000}),
        .ADDR_PATTERN ({32'h00000000, 32'h00020000, 32'h00010000, 32'h00000000}),
        .DEFAULT_PORT (PN),
        .OUTSTD_DEPTH (DEPTH)
    ) u_dut (
        .rst_n        (rst_n),
        .clk          (clk),
        .dmem_req     (dmem_req),
        .dmem_req_ack (dmem_req_ack),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .port_req     (port_req),
        .port_req_ack (port_req_ack),
        .port_cmd     (port_cmd),
        .port_width   (port_width),
        .port_addr    (port_addr),
        .port_wdata   (port_wdata),
        .port_rdata   (port_rdata),
        .port_resp    (port_resp)
    );

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
        int          ready;
    } txn_t;

    txn_t exp_q[$];
    txn_t p_new;
    logic p_push = 1'b0;
    logic p_pop  = 1'b0;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Stimulus for the next cycle and the response profile of whatever gets accepted
    logic          s_req = 1'b0, s_cmd = 1'b0;
    logic [1:0]    s_width = '0;
    logic [31:0]   s_addr = '0, s_wdata = '0;
    logic [PN-1:0] s_ack = '1;
    int            s_stale = -1;
    int            n_delay = 1;
    logic [1:0]    n_resp = R_OK;
    logic [31:0]   n_data = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int msel(input logic [31:0] a);
        for (int i = 0; i < PN; i++) begin
            if ((a & MASKS[i]) == PATS[i]) return i;
        end
        return PN;
    endfunction

    task automatic step();
        int          sz, sel;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic        e_pop, e_issue, e_ack;
        logic [PN-1:0] e_preq;
        @(posedge clk);
        #1;
        if (p_pop)  void'(exp_q.pop_front());
        if (p_push) exp_q.push_back(p_new);
        p_pop  = 1'b0;
        p_push = 1'b0;
        cyc++;
        dmem_req     = s_req;
        dmem_cmd     = s_cmd;
        dmem_width   = s_width;
        dmem_addr    = s_addr;
        dmem_wdata   = s_wdata;
        port_req_ack = s_ack;
        // Each target answers its oldest accepted transaction once its latency has elapsed
        for (int p = 0; p < PN; p++) begin
            drv_resp[p]  = R_NOT;
            drv_rdata[p] = $urandom;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].port == p) begin
                    if (cyc >= exp_q[k].ready) begin
                        drv_resp[p]  = exp_q[k].resp;
                        drv_rdata[p] = exp_q[k].data;
                    end
                    break;
                end
            end
            if (p == s_stale) drv_resp[p] = R_OK;
        end
        @(negedge clk);
        sz      = exp_q.size();
        e_resp  = R_NOT;
        e_rdata = '0;
        if (sz > 0) begin
            if (exp_q[0].port == PN) begin
                e_resp = R_ER;
            end else begin
                e_rdata = drv_rdata[exp_q[0].port];
                if (cyc >= exp_q[0].ready) e_resp = exp_q[0].resp;
            end
        end
        e_pop   = (e_resp != R_NOT);
        sel     = msel(s_addr);
        e_issue = s_req && (sz < DEPTH || e_pop)
                  && (sz == 0 || sel == exp_q[sz-1].port || (sz == 1 && e_pop));
        e_preq  = (e_issue && sel < PN) ? (PN'(1) << sel) : '0;
        e_ack   = e_issue && (sel == PN || s_ack[sel]);
        chk("dmem_resp",  {62'd0, dmem_resp}, {62'd0, e_resp});
        chk("dmem_rdata", {32'd0, dmem_rdata}, {32'd0, e_rdata});
        chk("port_req",   {60'd0, port_req}, {60'd0, e_preq});
        chk("req_ack",    {63'd0, dmem_req_ack}, {63'd0, e_ack});
        chk("broadcast",  {29'd0, port_cmd, port_width, port_addr},
                          {29'd0, s_cmd, s_width, s_addr});
        chk("bcast_wdata", {32'd0, port_wdata}, {32'd0, s_wdata});
        p_pop  = e_pop;
        p_push = e_ack;
        p_new  = '{port: sel, resp: n_resp, data: n_data, ready: cyc + n_delay};
    endtask

    task automatic set_req(input logic [31:0] a, input int d, input logic [1:0] r, input logic [31:0] dat);
        s_req   = 1'b1;
        s_addr  = a;
        n_delay = d;
        n_resp  = r;
        n_data  = dat;
    endtask

    task automatic idle();
        s_req = 1'b0;
    endtask

    // Async reset applied away from the clock edge; the model forgets everything outstanding
    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        p_push   = 1'b0;
        p_pop    = 1'b0;
        s_req    = 1'b0;
        dmem_req = 1'b0;
        for (int p = 0; p < PN; p++) drv_resp[p] = R_NOT;
        #1;
        chk("rst_resp",  {62'd0, dmem_resp}, 64'd0);
        chk("rst_ack",   {63'd0, dmem_req_ack}, 64'd0);
        chk("rst_preq",  {60'd0, port_req}, 64'd0);
        chk("rst_rdata", {32'd0, dmem_rdata}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int last_t;
        dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = '0; dmem_addr = '0; dmem_wdata = '0;
        port_req_ack = '1;
        for (int p = 0; p < PN; p++) begin
            drv_resp[p]  = R_NOT;
            drv_rdata[p] = '0;
        end
        @(negedge clk);
        do_reset();

        // Read to port1, answered the next cycle
        set_req(32'h00010004, 1, R_OK, 32'hCAFE0001);
        step();
        chk("t1_preq", {60'd0, port_req}, 64'h2);
        chk("t1_ack", {63'd0, dmem_req_ack}, 64'd1);
        idle();
        step();
        chk("t1_resp", {62'd0, dmem_resp}, 64'd1);
        chk("t1_rdata", {32'd0, dmem_rdata}, 64'hCAFE0001);
        step();
        chk("t1_empty", {62'd0, dmem_resp}, 64'd0);

        // Three reads to port0 with slow responses: third ack waits for the first pop
        set_req(32'h00000100, 3, R_OK, 32'hA0000001);
        step();
        set_req(32'h00000104, 3, R_OK, 32'hA0000002);
        step();
        chk("t2_ack2", {63'd0, dmem_req_ack}, 64'd1);
        set_req(32'h00000108, 3, R_OK, 32'hA0000003);
        step();
        chk("t2_hold", {63'd0, dmem_req_ack}, 64'd0);
        step();
        chk("t2_ack3", {63'd0, dmem_req_ack}, 64'd1);
        chk("t2_rdata1", {32'd0, dmem_rdata}, 64'hA0000001);
        idle();
        repeat (6) step();

        // Port0 outstanding blocks a request to port2 until the pop cycle
        set_req(32'h00000200, 3, R_OK, 32'hB0000001);
        step();
        set_req(32'h00020000, 1, R_OK, 32'hB0000002);
        step();
        chk("t3_block_req", {60'd0, port_req}, 64'd0);
        chk("t3_block_ack", {63'd0, dmem_req_ack}, 64'd0);
        step();
        step();
        chk("t3_issue_req", {60'd0, port_req}, 64'h4);
        chk("t3_issue_ack", {63'd0, dmem_req_ack}, 64'd1);
        idle();
        step();
        chk("t3_rdata2", {32'd0, dmem_rdata}, 64'hB0000002);

        // Unmapped address goes to the internal error responder
        set_req(32'hDEAD0000, 1, R_OK, 32'h0);
        step();
        chk("t4_ack", {63'd0, dmem_req_ack}, 64'd1);
        chk("t4_preq", {60'd0, port_req}, 64'd0);
        idle();
        step();
        chk("t4_resp", {62'd0, dmem_resp}, 64'd2);
        chk("t4_rdata", {32'd0, dmem_rdata}, 64'd0);

        // Error from port1 pops only the first of two outstanding reads
        set_req(32'h00010010, 2, R_ER, 32'hC0000001);
        step();
        set_req(32'h00010014, 3, R_OK, 32'hC0000002);
        step();
        idle();
        step();
        chk("t5_err", {62'd0, dmem_resp}, 64'd2);
        step();
        chk("t5_wait", {62'd0, dmem_resp}, 64'd0);
        step();
        chk("t5_ok", {62'd0, dmem_resp}, 64'd1);
        chk("t5_rdata", {32'd0, dmem_rdata}, 64'hC0000002);

        // Reset with two outstanding; a late response afterwards must be ignored
        set_req(32'h00000300, 6, R_OK, 32'hD0000001);
        step();
        set_req(32'h00000304, 6, R_OK, 32'hD0000002);
        step();
        idle();
        step();
        do_reset();
        s_stale = 0;
        step();
        chk("t6_stale", {62'd0, dmem_resp}, 64'd0);
        s_stale = -1;
        set_req(32'h00030000, 1, R_OK, 32'hD0000003);
        step();
        chk("t6_preq", {60'd0, port_req}, 64'h8);
        chk("t6_ack", {63'd0, dmem_req_ack}, 64'd1);
        idle();
        step();
        chk("t6_resp", {62'd0, dmem_resp}, 64'd1);
        chk("t6_rdata", {32'd0, dmem_rdata}, 64'hD0000003);

        // Randomized traffic with target stickiness so same-port bursts are common
        last_t = 0;
        for (int i = 0; i < 3000; i++) begin
            int t;
            t = (($urandom % 10) < 6) ? last_t : int'($urandom % 6);
            last_t = t;
            case (t)
                0: s_addr = {16'h0000, 16'($urandom)};
                1: s_addr = {16'h0001, 16'($urandom)};
                2: s_addr = {16'h0002, 16'($urandom)};
                3: s_addr = {16'($urandom_range(3, 16'h0FFF)), 16'($urandom)};
                4: s_addr = {16'hDEAD, 16'($urandom)};
                default: s_addr = {4'($urandom_range(1, 15)), 28'($urandom)};
            endcase
            s_req   = (($urandom % 4) != 0);
            s_cmd   = 1'($urandom);
            s_width = 2'($urandom_range(0, 2));
            s_wdata = $urandom;
            s_ack   = PN'($urandom);
            n_delay = int'($urandom_range(1, 4));
            n_resp  = (($urandom % 6) == 0) ? R_ER : R_OK;
            n_data  = $urandom;
            step();
            if (i == 1500) do_reset();
        end
        idle();
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
